// File: rtl/mmio_bridge.sv
// CPU load/store bridge: turns a slow 4-phase req/ack request into a single
// one-cycle pulse on either the I/O bus or the synchronous data-memory port.
module mmio_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h0000_7F00,
  parameter logic [7:0]  IO_LAST    = 8'h18,
  parameter int unsigned DM_AW      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [7:0]            io_addr,
  output logic [DATA_WIDTH-1:0] io_dout,
  input  logic [DATA_WIDTH-1:0] io_din,
  output logic                  io_we,
  output logic                  io_rd,
  output logic [DM_AW-1:0]      dm_addr,
  output logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_rdata
);

  typedef enum logic [2:0] {IDLE, IO_ACC, MEM_ACC, MEM_WAIT, DONE} state_t;

  state_t state;
  logic   wr;
  logic   io_hit;
  logic   io_legal;

  // Address decode on the live request; only sampled while IDLE.
  assign io_hit   = (cpu_addr[31:8] == IO_BASE[31:8]);
  assign io_legal = (cpu_addr[1:0] == 2'b00) && (cpu_addr[7:0] <= IO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wr        <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      io_addr   <= '0;
      io_dout   <= '0;
      io_we     <= 1'b0;
      io_rd     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      dm_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            wr <= cpu_wr;
            if (io_hit && io_legal) begin
              io_addr <= cpu_addr[7:0];
              io_dout <= cpu_wdata;
              io_we   <= cpu_wr;
              io_rd   <= !cpu_wr;
              state   <= IO_ACC;
            end else if (io_hit) begin
              // Illegal I/O access completes immediately without touching the bus.
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
              cpu_ack   <= 1'b1;
              state     <= DONE;
            end else begin
              dm_addr  <= cpu_addr[DM_AW+1:2];
              dm_wdata <= cpu_wdata;
              dm_we    <= cpu_wr;
              state    <= MEM_ACC;
            end
          end
        end
        IO_ACC: begin
          cpu_rdata <= wr ? '0 : io_din;
          io_we     <= 1'b0;
          io_rd     <= 1'b0;
          cpu_ack   <= 1'b1;
          cpu_err   <= 1'b0;
          state     <= DONE;
        end
        MEM_ACC: begin
          dm_we <= 1'b0;
          state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          cpu_rdata <= wr ? '0 : dm_rdata;
          cpu_ack   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Hold the response until the CPU releases its request.
          if (!cpu_req) begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
